// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter of NUM_CH requesters onto one shared memory bus
module mem_bus_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 2,
    parameter int MEM_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_write_mode,
    output logic                     mem_drive,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    last_q;
    logic [PTR_W-1:0]    owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_CH-1:0]   gnt_q;
    logic [NUM_CH-1:0]   rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_wm_q;
    logic                mem_drive_q;

    logic [PTR_W-1:0]    win_d;
    logic                win_found_d;
    int                  cand;
    logic [PTR_W-1:0]    cand_idx;

    // First requester found scanning upward from the channel after the last winner.
    always_comb begin
        win_d       = '0;
        win_found_d = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand     = (int'(last_q) + 1 + i) % NUM_CH;
            cand_idx = cand[PTR_W-1:0];
            if (!win_found_d && req[cand_idx]) begin
                win_found_d = 1'b1;
                win_d       = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= PTR_W'(NUM_CH - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wm_q    <= 1'b0;
            mem_drive_q <= 1'b0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state_q)
                IDLE: begin
                    mem_wm_q    <= 1'b0;
                    mem_drive_q <= 1'b0;
                    cnt_q       <= '0;
                    if (win_found_d) begin
                        mem_addr_q  <= addr[win_d*ADDR_W +: ADDR_W];
                        mem_wdata_q <= wdata[win_d*DATA_W +: DATA_W];
                        gnt_q       <= NUM_CH'(1) << win_d;
                        last_q      <= win_d;
                        owner_q     <= win_d;
                        if (we[win_d]) begin
                            state_q     <= WRITE;
                            mem_wm_q    <= 1'b1;
                            mem_drive_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    state_q     <= IDLE;
                    mem_wm_q    <= 1'b0;
                    mem_drive_q <= 1'b0;
                end
                READ: begin
                    // Address has been on the bus for MEM_LATENCY cycles at this edge.
                    if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                        rdata_q  <= mem_rdata;
                        rvalid_q <= NUM_CH'(1) << owner_q;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt            = gnt_q;
    assign rvalid         = rvalid_q;
    assign rdata          = rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_write_mode = mem_wm_q;
    assign mem_drive      = mem_drive_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter (2ch/lat1 and 4ch/lat3 instances)
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: NUM_CH=2, MEM_LATENCY=1
    logic        rst_a;
    logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
    logic [23:0] addr_a;
    logic [31:0] wdata_a;
    logic [15:0] rdata_a, mem_wdata_a, mem_rdata_a;
    logic [11:0] mem_addr_a;
    logic        mwm_a, mdrv_a;
    logic [15:0] mem_a [0:4095];

    mem_bus_arbiter #(.ADDR_W(12), .DATA_W(16), .NUM_CH(2), .MEM_LATENCY(1)) u_a (
        .clk(clk), .reset(rst_a), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_write_mode(mwm_a), .mem_drive(mdrv_a),
        .mem_rdata(mem_rdata_a));

    assign mem_rdata_a = mem_a[mem_addr_a];
    always @(posedge clk) if (mdrv_a && mwm_a) mem_a[mem_addr_a] <= mem_wdata_a;

    // instance B: NUM_CH=4, MEM_LATENCY=3
    logic        rst_b;
    logic [3:0]  req_b, we_b, gnt_b, rvalid_b;
    logic [47:0] addr_b;
    logic [63:0] wdata_b;
    logic [15:0] rdata_b, mem_wdata_b, mem_rdata_b;
    logic [11:0] mem_addr_b;
    logic        mwm_b, mdrv_b;
    logic [15:0] mem_b [0:4095];

    mem_bus_arbiter #(.ADDR_W(12), .DATA_W(16), .NUM_CH(4), .MEM_LATENCY(3)) u_b (
        .clk(clk), .reset(rst_b), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_write_mode(mwm_b), .mem_drive(mdrv_b),
        .mem_rdata(mem_rdata_b));

    assign mem_rdata_b = mem_b[mem_addr_b];
    always @(posedge clk) if (mdrv_b && mwm_b) mem_b[mem_addr_b] <= mem_wdata_b;

    logic [63:0] gq_a[$], rq_a[$], gq_b[$], rq_b[$];

    function automatic logic [63:0] mk_g(logic [7:0] g, logic [11:0] a, logic [15:0] d,
                                         logic wm, logic drv);
        return {26'b0, g, a, d, wm, drv};
    endfunction

    function automatic logic [63:0] mk_r(logic [7:0] v, logic [15:0] d);
        return {40'b0, v, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] v);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got pulse %b expected none", name, v);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no response expected one within bound", name);
    endtask

    task automatic wait_drain(input string name, input int which);
        int sz;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            case (which)
                0:       sz = gq_a.size();
                1:       sz = rq_a.size();
                2:       sz = gq_b.size();
                default: sz = rq_b.size();
            endcase
            if (sz == 0) return;
        end
        timeout(name);
    endtask

    task automatic hs_a(input int ch);
        bit ok = 0;
        req_a[ch] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (gnt_a[ch]) begin ok = 1; break; end
        end
        if (!ok) timeout("a_handshake");
        @(posedge clk);
        #1;
        req_a[ch] = 1'b0;
    endtask

    task automatic hs_b(input int ch);
        bit ok = 0;
        req_b[ch] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (gnt_b[ch]) begin ok = 1; break; end
        end
        if (!ok) timeout("b_handshake");
        @(posedge clk);
        #1;
        req_b[ch] = 1'b0;
    endtask

    // monitors: pop expectations whenever the DUT presents gnt or rvalid
    bit          busy_a = 0, busy_b = 0;
    int          gc_a = 0, gc_b = 0;
    logic [15:0] prev_rd_a = '0, prev_rd_b = '0;

    always @(negedge clk) begin
        if (rst_a) begin
            busy_a = 0;
        end else begin
            check("a_gnt_onehot", 64'($onehot0(gnt_a)), 64'd1);
            check("a_rvalid_onehot", 64'($onehot0(rvalid_a)), 64'd1);
            check("a_drive_vs_wmode", 64'(mdrv_a), 64'(mwm_a));
            if (rvalid_a == 0) check("a_rdata_hold", 64'(rdata_a), 64'(prev_rd_a));
            if (gnt_a != 0) begin
                check("a_gnt_during_read", 64'(busy_a), 64'd0);
                if (gq_a.size() == 0) unexpected("a_gnt", 8'(gnt_a));
                else check("a_gnt", mk_g(8'(gnt_a), mem_addr_a, mem_wdata_a, mwm_a, mdrv_a),
                           gq_a.pop_front());
                gc_a   = cyc;
                busy_a = !mwm_a;
            end
            if (rvalid_a != 0) begin
                if (rq_a.size() == 0) unexpected("a_rvalid", 8'(rvalid_a));
                else check("a_rvalid", mk_r(8'(rvalid_a), rdata_a), rq_a.pop_front());
                check("a_read_latency", 64'(cyc - gc_a), 64'd1);
                busy_a = 0;
            end
        end
        prev_rd_a = rdata_a;
    end

    always @(negedge clk) begin
        if (rst_b) begin
            busy_b = 0;
        end else begin
            check("b_gnt_onehot", 64'($onehot0(gnt_b)), 64'd1);
            check("b_rvalid_onehot", 64'($onehot0(rvalid_b)), 64'd1);
            check("b_drive_vs_wmode", 64'(mdrv_b), 64'(mwm_b));
            if (rvalid_b == 0) check("b_rdata_hold", 64'(rdata_b), 64'(prev_rd_b));
            if (gnt_b != 0) begin
                check("b_gnt_during_read", 64'(busy_b), 64'd0);
                if (gq_b.size() == 0) unexpected("b_gnt", 8'(gnt_b));
                else check("b_gnt", mk_g(8'(gnt_b), mem_addr_b, mem_wdata_b, mwm_b, mdrv_b),
                           gq_b.pop_front());
                gc_b   = cyc;
                busy_b = !mwm_b;
            end
            if (rvalid_b != 0) begin
                if (rq_b.size() == 0) unexpected("b_rvalid", 8'(rvalid_b));
                else check("b_rvalid", mk_r(8'(rvalid_b), rdata_b), rq_b.pop_front());
                check("b_read_latency", 64'(cyc - gc_b), 64'd3);
                busy_b = 0;
            end
        end
        prev_rd_b = rdata_b;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_a = 1'b1; req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        rst_b = 1'b1; req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[12'hFFA] = 16'hCCCC;
        mem_a[12'hFF8] = 16'hDDDD;
        mem_b[12'h123] = 16'h5A5A;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_reset_gnt_rvalid", 64'({gnt_a, rvalid_a}), 64'd0);
        check("a_reset_bus", 64'({rdata_a, mem_addr_a, mem_wdata_a, mwm_a, mdrv_a}), 64'd0);
        @(posedge clk);
        #1 rst_a = 1'b0;

        // contention from reset: ch0 first, then alternating while both held
        addr_a  = {12'hFF8, 12'hFFA};
        wdata_a = {16'h2222, 16'h1111};
        we_a    = 2'b00;
        for (int r = 0; r < 2; r++) begin
            gq_a.push_back(mk_g(8'h01, 12'hFFA, 16'h1111, 1'b0, 1'b0));
            rq_a.push_back(mk_r(8'h01, 16'hCCCC));
            gq_a.push_back(mk_g(8'h02, 12'hFF8, 16'h2222, 1'b0, 1'b0));
            rq_a.push_back(mk_r(8'h02, 16'hDDDD));
        end
        req_a = 2'b11;
        wait_drain("a_contention_grants", 0);
        req_a = 2'b00;
        wait_drain("a_contention_reads", 1);

        repeat (10) @(posedge clk);
        #1;
        check("a_rdata_hold_10_idle", 64'(rdata_a), 64'hDDDD);

        // single write
        addr_a[11:0]  = 12'hFFE;
        wdata_a[15:0] = 16'hAAAA;
        we_a[0]       = 1'b1;
        gq_a.push_back(mk_g(8'h01, 12'hFFE, 16'hAAAA, 1'b1, 1'b1));
        hs_a(0);
        check("a_write_mem", 64'(mem_a[12'hFFE]), 64'hAAAA);
        check("a_write_back_idle", 64'({mwm_a, mdrv_a}), 64'd0);
        check("a_rdata_hold_write", 64'(rdata_a), 64'hDDDD);

        // write then read back from the other channel
        addr_a[11:0]  = 12'hFFC;
        wdata_a[15:0] = 16'hBBBB;
        gq_a.push_back(mk_g(8'h01, 12'hFFC, 16'hBBBB, 1'b1, 1'b1));
        hs_a(0);
        we_a[0]        = 1'b0;
        addr_a[23:12]  = 12'hFFC;
        gq_a.push_back(mk_g(8'h02, 12'hFFC, 16'h2222, 1'b0, 1'b0));
        rq_a.push_back(mk_r(8'h02, 16'hBBBB));
        hs_a(1);
        wait_drain("a_write_read", 1);
        check("a_rdata_after_read", 64'(rdata_a), 64'hBBBB);

        // reset during READ abandons the read
        addr_a[11:0]  = 12'hFFA;
        wdata_a[15:0] = 16'h3333;
        gq_a.push_back(mk_g(8'h01, 12'hFFA, 16'h3333, 1'b0, 1'b0));
        req_a[0] = 1'b1;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (gnt_a[0]) begin ok = 1; break; end
        end
        if (!ok) timeout("a_midreset_gnt");
        @(negedge clk);
        #1;
        rst_a    = 1'b1;
        req_a[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("a_midreset_gnt_rvalid", 64'({gnt_a, rvalid_a}), 64'd0);
        check("a_midreset_bus", 64'({rdata_a, mem_addr_a, mem_wdata_a, mwm_a, mdrv_a}), 64'd0);
        @(posedge clk);
        #1 rst_a = 1'b0;
        repeat (3) @(posedge clk);

        // priority restarts at ch0 after reset
        #1;
        addr_a  = {12'hFF8, 12'hFFA};
        wdata_a = {16'h2222, 16'h1111};
        we_a    = 2'b00;
        gq_a.push_back(mk_g(8'h01, 12'hFFA, 16'h1111, 1'b0, 1'b0));
        rq_a.push_back(mk_r(8'h01, 16'hCCCC));
        gq_a.push_back(mk_g(8'h02, 12'hFF8, 16'h2222, 1'b0, 1'b0));
        rq_a.push_back(mk_r(8'h02, 16'hDDDD));
        fork
            hs_a(0);
            hs_a(1);
        join
        wait_drain("a_post_reset", 1);

        // instance B: latency 3 read on ch2, then rotation 3,0,1
        @(negedge clk);
        check("b_reset_outs", 64'({gnt_b, rvalid_b, rdata_b, mem_addr_b, mwm_b, mdrv_b}), 64'd0);
        @(posedge clk);
        #1 rst_b = 1'b0;
        addr_b  = {12'h013, 12'h123, 12'h011, 12'h010};
        wdata_b = {16'h1003, 16'h2020, 16'h1001, 16'h1000};
        we_b    = 4'b1011;
        gq_b.push_back(mk_g(8'h04, 12'h123, 16'h2020, 1'b0, 1'b0));
        rq_b.push_back(mk_r(8'h04, 16'h5A5A));
        gq_b.push_back(mk_g(8'h08, 12'h013, 16'h1003, 1'b1, 1'b1));
        gq_b.push_back(mk_g(8'h01, 12'h010, 16'h1000, 1'b1, 1'b1));
        gq_b.push_back(mk_g(8'h02, 12'h011, 16'h1001, 1'b1, 1'b1));
        req_b[2] = 1'b1;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (gnt_b[2]) begin ok = 1; break; end
        end
        if (!ok) timeout("b_ch2_gnt");
        req_b = req_b | 4'b1011;
        @(posedge clk);
        #1 req_b[2] = 1'b0;
        fork
            hs_b(0);
            hs_b(1);
            hs_b(3);
        join
        wait_drain("b_reads", 3);
        wait_drain("b_grants", 2);
        repeat (2) @(posedge clk);
        #1;
        check("b_mem_ch0", 64'(mem_b[12'h010]), 64'h1000);
        check("b_mem_ch1", 64'(mem_b[12'h011]), 64'h1001);
        check("b_mem_ch3", 64'(mem_b[12'h013]), 64'h1003);

        check("a_gnt_queue_empty", 64'(gq_a.size()), 64'd0);
        check("a_rvalid_queue_empty", 64'(rq_a.size()), 64'd0);
        check("b_gnt_queue_empty", 64'(gq_b.size()), 64'd0);
        check("b_rvalid_queue_empty", 64'(rq_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Parametrised successor to the single-master memory bus hookup: arbitrates NUM_CH requesters (e.g. instruction fetch, data port, debug loader) onto one shared Memory bus.
- Bus signals are address, data and write_mode.
- Round-robin grant, per-channel request/grant/read-valid handshake, configurable memory read latency.
- Sits between the BU2020 core ports and the Memory instance; the top level builds the tristate data bus from mem_wdata/mem_drive.

Parameters:
- ADDR_W, 12, address width.
- DATA_W, 16, data width.
- NUM_CH, 2, number of requesting channels (>=1).
- MEM_LATENCY, 1, cycles from read address on bus to mem_rdata valid (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel access request, held until granted.
- we  in  NUM_CH  per-channel write enable (1=write, 0=read).
- addr  in  NUM_CH*ADDR_W  per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CH*DATA_W  per-channel write data, same packing.
- gnt  out  NUM_CH  one-cycle pulse: request accepted.
- rvalid  out  NUM_CH  one-cycle pulse: read data ready for that channel.
- rdata  out  DATA_W  shared read data; valid while rvalid is set, held otherwise.
- mem_addr  out  ADDR_W  memory address bus.
- mem_wdata  out  DATA_W  memory write data.
- mem_write_mode  out  1  memory write_mode.
- mem_drive  out  1  tristate enable for the data bus at the top level.
- mem_rdata  in  DATA_W  data bus value read back from Memory.

Behaviour:
- Reset (synchronous, also mid-operation):
  - state=IDLE, all outputs 0, latency counter 0.
  - Round-robin pointer set so channel 0 has top priority.
  - An in-flight transaction is abandoned; no gnt or rvalid follows.
- States: IDLE, WRITE, READ. All outputs are registered.
- IDLE:
  - mem_write_mode=0, mem_drive=0; mem_addr and mem_wdata hold their last values.
  - On an edge with any req high, pick the winner by round-robin: search starts at (last_winner+1) mod NUM_CH.
  - Register the winner's addr into mem_addr and wdata into mem_wdata.
  - Set gnt[winner]=1 for exactly the next cycle and update last_winner.
  - Go to WRITE if we[winner]=1, else READ.
- WRITE (1 cycle): mem_write_mode=1, mem_drive=1, gnt pulse high. Next edge returns to IDLE.
- READ:
  - mem_write_mode=0, mem_drive=0, counter counts MEM_LATENCY cycles from entry.
  - On the edge ending the last cycle, capture mem_rdata into rdata.
  - Pulse rvalid[owner] for one cycle and return to IDLE.
  - Read-to-rvalid latency from the granting edge is MEM_LATENCY cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - It may drop or change them on the edge that ends the gnt cycle.
  - The arbiter never samples req outside IDLE, so a re-request starts no earlier than the IDLE cycle.
- Throughput:
  - One write per 2 cycles.
  - One read per MEM_LATENCY+1 cycles.
  - No pipelining of overlapped transactions.
- Simultaneous req: exactly one gnt bit is ever set; the others wait. A continuously requesting channel is served at most once per NUM_CH grants when all channels request.
- NUM_CH=1: the pointer is constant and behaviour reduces to a single-master sequencer.
- rvalid and gnt are never high for two channels in the same cycle.
- mem_drive=1 only in WRITE.

Test Plan:
- Single write: ch0 req, we=1, addr=0xFFE, wdata=0xAAAA -> gnt[0] the next cycle, and in that cycle mem_addr=0xFFE, mem_wdata=0xAAAA, mem_write_mode=1, mem_drive=1. IDLE 1 cycle later; Memory[0xFFE]=0xAAAA.
- Write then read (MEM_LATENCY=1):
  - Ch0 writes 0xBBBB to 0xFFC; ch1 then reads 0xFFC.
  - gnt[1] with mem_write_mode=0.
  - rvalid[1] one cycle after gnt, with rdata=0xBBBB.
- Contention:
  - Ch0 and ch1 both request reads of 0xFFA/0xFF8 (preloaded 0xCCCC/0xDDDD) from reset.
  - Ch0 is granted first, rdata=0xCCCC.
  - Ch1 next, rdata=0xDDDD.
  - Both held high -> grants alternate 0,1,0,1.
- Latency sweep: MEM_LATENCY=3, NUM_CH=4, ch2 read -> rvalid[2] exactly 3 cycles after gnt[2]; no other gnt during the read.
- Reset mid-read: assert reset during READ -> next cycle all outputs 0 and no rvalid; the subsequent ch1 request is granted normally with priority starting at ch0.
- Hold check: rdata stays 0xDDDD through 10 idle cycles and a subsequent write; it changes only on the next rvalid.
